// File: rtl/mfcc_frame_collector.sv
// mfcc_frame_collector: groups the free-running MFCC coefficient stream into
// frames, buffers up to DEPTH_FRAMES whole frames in a ring and replays them
// oldest-first over a valid/ready stream with first/last markers.
// Optional: define MFCC_DROP_CNT_EN to add the saturating drop_count output.
module mfcc_frame_collector #(
    parameter int COEF_W       = 32,
    parameter int MAX_COEFFS   = 16,
    parameter int DEPTH_FRAMES = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [COEF_W-1:0]             mfcc_in,
    input  logic                          mfcc_in_valid,
    input  logic [7:0]                    num_mfcc_coeffs,
    output logic [COEF_W-1:0]             feat_out,
    output logic                          feat_valid,
    input  logic                          feat_ready,
    output logic                          feat_first,
    output logic                          feat_last,
    output logic [$clog2(DEPTH_FRAMES):0] frames_avail,
    output logic                          overflow,
    input  logic                          clear_ovf
`ifdef MFCC_DROP_CNT_EN
    ,
    output logic [15:0]                   drop_count
`endif
);

    localparam int SW = $clog2(DEPTH_FRAMES);
    localparam int IW = (MAX_COEFFS > 1) ? $clog2(MAX_COEFFS) : 1;
    localparam int LW = $clog2(MAX_COEFFS + 1);
    localparam int FW = SW + 1;
    localparam int AW = SW + IW;
    localparam logic [7:0]    MAX_N8     = 8'(MAX_COEFFS);
    localparam logic [FW-1:0] FULL_LEVEL = FW'(DEPTH_FRAMES);
    localparam logic [FW-1:0] ONE_FRAME  = FW'(1);
    localparam logic [LW-1:0] LEN_ONE    = LW'(1);

    typedef enum logic [1:0] {W_IDLE, W_FILL, W_DROP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_STREAM} r_state_t;

    // Coefficient store addressed {slot, index}, plus the length of each slot.
    logic [COEF_W-1:0] mem     [1 << AW];
    logic [LW-1:0]     len_mem [DEPTH_FRAMES];
    logic [COEF_W-1:0] rd_data;

    // Write side
    w_state_t        w_state;
    logic [SW-1:0]   wr_ptr;
    logic [LW-1:0]   wcnt;
    logic [LW-1:0]   w_len;
    logic [LW-1:0]   frame_len;
    logic            has_room;
    logic            wr_en;
    logic [IW-1:0]   wr_idx;
    logic            commit;

    // Read side
    r_state_t        r_state;
    logic [SW-1:0]   rd_ptr;
    logic [SW-1:0]   rd_ptr_next;
    logic [LW-1:0]   rd_idx;
    logic [LW-1:0]   r_len;
    logic            rd_en;
    logic [SW-1:0]   rd_slot;
    logic [IW-1:0]   rd_cidx;
    logic            more_frames;
    logic            release_frame;

    assign has_room      = (frames_avail < FULL_LEVEL);
    assign more_frames   = (frames_avail > ONE_FRAME);
    assign rd_ptr_next   = rd_ptr + 1'b1;
    assign release_frame = (r_state == R_STREAM) && feat_ready && feat_last;

    // Clamp the requested frame length into 1..MAX_COEFFS.
    // NOTE: every combinational output gets a value on every path (defaults
    // first), otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        frame_len = num_mfcc_coeffs[LW-1:0];
        if (num_mfcc_coeffs == 8'd0) begin
            frame_len = LEN_ONE;
        end else if (num_mfcc_coeffs > MAX_N8) begin
            frame_len = LW'(MAX_COEFFS);
        end
    end

    // Decode this cycle's buffer write and frame commit from the write FSM.
    always_comb begin
        wr_en  = 1'b0;
        wr_idx = '0;
        commit = 1'b0;
        if (mfcc_in_valid) begin
            case (w_state)
                W_IDLE: begin
                    if (has_room) begin
                        wr_en  = 1'b1;
                        commit = (frame_len == LEN_ONE);
                    end
                end
                W_FILL: begin
                    wr_en  = 1'b1;
                    wr_idx = wcnt[IW-1:0];
                    commit = (wcnt == w_len - LEN_ONE);
                end
                default: ;
            endcase
        end
    end

    // Write FSM: admit a frame only if a slot is free at its first coefficient,
    // otherwise swallow the whole frame and flag the overflow.
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            w_state  <= W_IDLE;
            wr_ptr   <= '0;
            wcnt     <= '0;
            w_len    <= LEN_ONE;
            overflow <= 1'b0;
`ifdef MFCC_DROP_CNT_EN
            drop_count <= '0;
`endif
        end else begin
            if (clear_ovf) begin
                overflow <= 1'b0;
`ifdef MFCC_DROP_CNT_EN
                drop_count <= '0;
`endif
            end
            if (mfcc_in_valid) begin
                case (w_state)
                    W_IDLE: begin
                        w_len <= frame_len;
                        wcnt  <= LEN_ONE;
                        if (has_room) begin
                            if (frame_len == LEN_ONE) begin
                                wr_ptr <= wr_ptr + 1'b1;
                            end else begin
                                w_state <= W_FILL;
                            end
                        end else begin
                            // Later assignment overrides a same-cycle clear.
                            overflow <= 1'b1;
`ifdef MFCC_DROP_CNT_EN
                            if (drop_count != 16'hFFFF) begin
                                drop_count <= drop_count + 16'd1;
                            end
`endif
                            // A one-coefficient frame is already fully consumed.
                            if (frame_len != LEN_ONE) begin
                                w_state <= W_DROP;
                            end
                        end
                    end
                    W_FILL: begin
                        if (commit) begin
                            wr_ptr  <= wr_ptr + 1'b1;
                            w_state <= W_IDLE;
                        end else begin
                            wcnt <= wcnt + 1'b1;
                        end
                    end
                    W_DROP: begin
                        if (wcnt == w_len - LEN_ONE) begin
                            w_state <= W_IDLE;
                        end else begin
                            wcnt <= wcnt + 1'b1;
                        end
                    end
                    default: w_state <= W_IDLE;
                endcase
            end
        end
    end

    // Pick the RAM read: slot head on fetch, otherwise one ahead of feat_out.
    always_comb begin
        rd_en   = 1'b0;
        rd_slot = rd_ptr;
        rd_cidx = '0;
        case (r_state)
            R_IDLE:  rd_en = (frames_avail != '0);
            R_FETCH: begin
                rd_en   = 1'b1;
                rd_cidx = IW'(1);
            end
            R_STREAM: begin
                if (feat_ready) begin
                    if (feat_last) begin
                        rd_en   = more_frames;
                        rd_slot = rd_ptr_next;
                    end else begin
                        rd_en   = 1'b1;
                        rd_cidx = IW'(rd_idx + LW'(2));
                    end
                end
            end
            default: ;
        endcase
    end

    // Coefficient RAM with one write port and one registered read port;
    // rd_data doubles as the prefetch register that sustains 1 beat/cycle.
    // NOTE: storage arrays are not reset; occupancy is tracked by pointers and
    // frames_avail, so stale contents are never presented.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[{wr_ptr, wr_idx}] <= mfcc_in;
            if (w_state == W_IDLE) begin
                len_mem[wr_ptr] <= frame_len;
            end
        end
        if (rd_en) begin
            rd_data <= mem[{rd_slot, rd_cidx}];
        end
    end

    // Read FSM: fetch bubble, then stream the slot with registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= R_IDLE;
            rd_ptr     <= '0;
            rd_idx     <= '0;
            r_len      <= LEN_ONE;
            feat_out   <= '0;
            feat_valid <= 1'b0;
            feat_first <= 1'b0;
            feat_last  <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (frames_avail != '0) begin
                        r_len   <= len_mem[rd_ptr];
                        r_state <= R_FETCH;
                    end
                end
                R_FETCH: begin
                    feat_out   <= rd_data;
                    feat_valid <= 1'b1;
                    feat_first <= 1'b1;
                    feat_last  <= (r_len == LEN_ONE);
                    rd_idx     <= '0;
                    r_state    <= R_STREAM;
                end
                R_STREAM: begin
                    if (feat_ready) begin
                        if (feat_last) begin
                            rd_ptr     <= rd_ptr_next;
                            feat_valid <= 1'b0;
                            feat_first <= 1'b0;
                            feat_last  <= 1'b0;
                            if (more_frames) begin
                                r_len   <= len_mem[rd_ptr_next];
                                r_state <= R_FETCH;
                            end else begin
                                r_state <= R_IDLE;
                            end
                        end else begin
                            feat_out   <= rd_data;
                            feat_first <= 1'b0;
                            feat_last  <= (rd_idx + LW'(2) == r_len);
                            rd_idx     <= rd_idx + 1'b1;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Occupancy: +1 on commit, -1 on release, unchanged when both coincide.
    always_ff @(posedge clk) begin
        if (rst) begin
            frames_avail <= '0;
        end else if (commit && !release_frame) begin
            frames_avail <= frames_avail + 1'b1;
        end else if (!commit && release_frame) begin
            frames_avail <= frames_avail - 1'b1;
        end
    end

endmodule

// File: tb/tb_mfcc_frame_collector.sv
// Self-checking bench for mfcc_frame_collector: directed scenarios plus
// randomized frames scored against a frame-level queue model.
module tb_mfcc_frame_collector;

    localparam int COEF_W = 32;
    localparam int MAXC   = 16;

    typedef logic [COEF_W+1:0] beat_t;   // {coef, first, last}

    logic              clk = 1'b0;
    logic              rst;
    logic [COEF_W-1:0] mfcc_in;
    logic              mfcc_in_valid;
    logic [7:0]        num_mfcc_coeffs;
    logic              feat_ready;
    logic              clear_ovf;

    logic [COEF_W-1:0] feat_out, feat_out2;
    logic              feat_valid, feat_valid2;
    logic              feat_first, feat_first2;
    logic              feat_last, feat_last2;
    logic [3:0]        frames_avail;
    logic [1:0]        frames_avail2;
    logic              overflow, overflow2;
`ifdef MFCC_DROP_CNT_EN
    logic [15:0]       drop_count, drop_count2;
`endif

    mfcc_frame_collector #(.COEF_W(COEF_W), .MAX_COEFFS(MAXC), .DEPTH_FRAMES(8)) dut (
        .clk(clk), .rst(rst), .mfcc_in(mfcc_in), .mfcc_in_valid(mfcc_in_valid),
        .num_mfcc_coeffs(num_mfcc_coeffs), .feat_out(feat_out), .feat_valid(feat_valid),
        .feat_ready(feat_ready), .feat_first(feat_first), .feat_last(feat_last),
        .frames_avail(frames_avail), .overflow(overflow), .clear_ovf(clear_ovf)
`ifdef MFCC_DROP_CNT_EN
        , .drop_count(drop_count)
`endif
    );

    mfcc_frame_collector #(.COEF_W(COEF_W), .MAX_COEFFS(MAXC), .DEPTH_FRAMES(2)) dut2 (
        .clk(clk), .rst(rst), .mfcc_in(mfcc_in), .mfcc_in_valid(mfcc_in_valid),
        .num_mfcc_coeffs(num_mfcc_coeffs), .feat_out(feat_out2), .feat_valid(feat_valid2),
        .feat_ready(feat_ready), .feat_first(feat_first2), .feat_last(feat_last2),
        .frames_avail(frames_avail2), .overflow(overflow2), .clear_ovf(clear_ovf)
`ifdef MFCC_DROP_CNT_EN
        , .drop_count(drop_count2)
`endif
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_err    = 0;
    bit    rand_ready = 1'b0;
    beat_t rx_q[$];
    beat_t rx2_q[$];
    beat_t exp_q[$];

    // Record every handshake that the next rising edge will complete.
    always @(negedge clk) begin
        #1;
        if (!rst && feat_valid && feat_ready)  rx_q.push_back({feat_out, feat_first, feat_last});
        if (!rst && feat_valid2 && feat_ready) rx2_q.push_back({feat_out2, feat_first2, feat_last2});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Effective frame length from the requested count.
    function automatic int eff_len(input int num);
        if (num == 0) return 1;
        if (num > MAXC) return MAXC;
        return num;
    endfunction

    task automatic cycle();
        @(negedge clk);
        if (rand_ready) feat_ready = ($urandom_range(0, 2) != 0);
    endtask

    // Send one whole frame with random data; the length request is scrambled
    // after coefficient 0 since only the first one may matter.
    task automatic send_frame(input int num, input int gap_pct, input bit keep);
        int n;
        n = eff_len(num);
        for (int i = 0; i < n; i++) begin
            while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) begin
                cycle();
                mfcc_in_valid = 1'b0;
            end
            cycle();
            mfcc_in_valid   = 1'b1;
            mfcc_in         = $urandom;
            num_mfcc_coeffs = (i == 0) ? 8'(num) : 8'($urandom_range(0, 255));
            if (keep) exp_q.push_back({mfcc_in, i == 0, i == n - 1});
        end
        cycle();
        mfcc_in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int n, input bit second);
        for (int c = 0; c < 2000; c++) begin
            cycle();
            if ((second ? rx2_q.size() : rx_q.size()) >= n) break;
        end
        repeat (8) cycle();
    endtask

    task automatic compare_stream(input string tag, input bit second);
        int n_rx;
        n_rx = second ? rx2_q.size() : rx_q.size();
        check({tag, " beat count"}, 64'(n_rx), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < n_rx; i++)
            check(tag, second ? rx2_q[i] : rx_q[i], exp_q[i]);
    endtask

    task automatic clear_queues();
        rx_q.delete();
        rx2_q.delete();
        exp_q.delete();
    endtask

    logic [COEF_W-1:0] t1 [4];
    bit    pat [4];
    bit    prev_stall;
    beat_t prev_beat;

    initial begin
        t1  = '{32'h11, 32'h22, 32'h33, 32'h44};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        rst = 1'b1; mfcc_in = '0; mfcc_in_valid = 1'b0; num_mfcc_coeffs = 8'd4;
        feat_ready = 1'b0; clear_ovf = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("reset feat_valid", feat_valid, 0);
        check("reset feat_first", feat_first, 0);
        check("reset feat_last", feat_last, 0);
        check("reset feat_out", feat_out, 0);
        check("reset frames_avail", frames_avail, 0);
        check("reset overflow", overflow, 0);

        // Single frame, reader always ready: exact latency and throughput
        feat_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mfcc_in_valid = 1'b1; mfcc_in = t1[i]; num_mfcc_coeffs = 8'd4;
        end
        @(negedge clk);
        mfcc_in_valid = 1'b0;
        check("t1 frames_avail after commit", frames_avail, 1);
        check("t1 valid at T", feat_valid, 0);
        @(negedge clk);
        check("t1 valid at T+1", feat_valid, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t1 valid streaming", feat_valid, 1);
            check("t1 beat", {feat_out, feat_first, feat_last}, {t1[k], k == 0, k == 3});
        end
        @(negedge clk);
        check("t1 valid after frame", feat_valid, 0);
        check("t1 frames_avail drained", frames_avail, 0);

        // Backpressure 1,0,0,1: stable while stalled, exactly 4 handshakes
        repeat (2) @(negedge clk);
        clear_queues();
        feat_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mfcc_in_valid = 1'b1; mfcc_in = t1[i]; num_mfcc_coeffs = 8'd4;
            exp_q.push_back({t1[i], i == 0, i == 3});
        end
        @(negedge clk);
        mfcc_in_valid = 1'b0;
        prev_stall = 1'b0;
        prev_beat  = '0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (prev_stall) check("t2 stable in stall", {feat_out, feat_first, feat_last}, prev_beat);
            feat_ready = pat[c % 4];
            prev_stall = feat_valid && !feat_ready;
            prev_beat  = {feat_out, feat_first, feat_last};
        end
        compare_stream("t2 backpressure stream", 1'b0);

        // Overflow: nine frames into eight slots with the reader stalled
        clear_queues();
        feat_ready = 1'b0;
        for (int f = 0; f < 9; f++) send_frame(4, 0, f < 8);
        check("t3 frames_avail full", frames_avail, 8);
        check("t3 overflow set", overflow, 1);
`ifdef MFCC_DROP_CNT_EN
        check("t3 drop_count", drop_count, 1);
`endif
        feat_ready = 1'b1;
        wait_drain(32, 1'b0);
        compare_stream("t3 replay oldest-first", 1'b0);
        check("t3 frames_avail drained", frames_avail, 0);
        check("t3 overflow sticky", overflow, 1);
        @(negedge clk); clear_ovf = 1'b1;
        @(negedge clk); clear_ovf = 1'b0;
        check("t3 overflow cleared", overflow, 0);
`ifdef MFCC_DROP_CNT_EN
        check("t3 drop_count cleared", drop_count, 0);
`endif

        // Length clamp and per-slot length: 0 -> 1, 20 -> 16, 3 -> 3
        clear_queues();
        feat_ready = 1'b1;
        send_frame(0, 30, 1'b1);
        send_frame(20, 30, 1'b1);
        send_frame(3, 30, 1'b1);
        wait_drain(20, 1'b0);
        compare_stream("t4 clamped lengths", 1'b0);

        // Randomized batches: never more than six frames pending, so none drop
        for (int b = 0; b < 4; b++) begin
            clear_queues();
            rand_ready = 1'b1;
            for (int f = 0; f < 6; f++) send_frame(int'($urandom_range(0, 20)), int'($urandom_range(0, 40)), 1'b1);
            rand_ready = 1'b0;
            feat_ready = 1'b1;
            wait_drain(exp_q.size(), 1'b0);
            compare_stream("t5 random batch", 1'b0);
            check("t5 frames_avail drained", frames_avail, 0);
        end

        // Simultaneous commit and release at frames_avail=2
        clear_queues();
        feat_ready = 1'b0;
        send_frame(4, 0, 1'b1);
        send_frame(4, 0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle();
            mfcc_in_valid = 1'b1; mfcc_in = $urandom;
            num_mfcc_coeffs = (i == 0) ? 8'd4 : 8'($urandom_range(0, 255));
            exp_q.push_back({mfcc_in, i == 0, 1'b0});
        end
        cycle();
        mfcc_in_valid = 1'b0;
        check("t6 frames_avail before", frames_avail, 2);
        feat_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (feat_valid && feat_last) begin
                feat_ready = 1'b0;
                break;
            end
        end
        check("t6 holding last of first frame", {feat_valid, feat_last}, 2'b11);
        @(negedge clk);
        mfcc_in_valid = 1'b1; mfcc_in = $urandom; feat_ready = 1'b1;
        exp_q.push_back({mfcc_in, 1'b0, 1'b1});
        @(negedge clk);
        mfcc_in_valid = 1'b0; feat_ready = 1'b0;
        check("t6 frames_avail unchanged", frames_avail, 2);
        feat_ready = 1'b1;
        wait_drain(8, 1'b0);
        compare_stream("t6 stream", 1'b0);
        check("t6 frames_avail drained", frames_avail, 0);

        // Two-slot ring: pointers wrap across 20 frames
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        clear_queues();
        feat_ready = 1'b1;
        for (int f = 0; f < 20; f++) begin
            send_frame(4, 0, 1'b1);
            repeat (2) cycle();
        end
        wait_drain(80, 1'b1);
        compare_stream("t7 ring-2 wrap", 1'b1);
        check("t7 frames_avail drained", frames_avail2, 0);
        check("t7 no overflow", overflow2, 0);

        // Reset in the middle of a frame and with a frame pending
        clear_queues();
        feat_ready = 1'b0;
        send_frame(4, 0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            cycle();
            mfcc_in_valid = 1'b1; mfcc_in = $urandom; num_mfcc_coeffs = 8'd4;
        end
        cycle();
        mfcc_in_valid = 1'b0; rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("t8 reset feat_valid", feat_valid, 0);
        check("t8 reset feat_first", feat_first, 0);
        check("t8 reset feat_last", feat_last, 0);
        check("t8 reset feat_out", feat_out, 0);
        check("t8 reset frames_avail", frames_avail, 0);
        check("t8 reset overflow", overflow, 0);
        clear_queues();
        feat_ready = 1'b1;
        send_frame(4, 0, 1'b1);
        wait_drain(4, 1'b0);
        compare_stream("t8 frame after reset", 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mfcc_frame_collector.md
Name: mfcc_frame_collector

Overview:
- Consumer end of the MFCC accelerator output stream: accepts the free-running mfcc_out/mfcc_valid coefficient stream, which has no backpressure.
- Groups coefficients into frames of num_mfcc_coeffs and stores up to DEPTH_FRAMES whole frames in a ring buffer.
- Replays frames oldest-first to the downstream classifier over a valid/ready stream with first/last markers.
- Frames that arrive while the buffer is full are dropped whole; a partial frame is never emitted.

Parameters:
- COEF_W, 32, coefficient width; matches mfcc_out.
- MAX_COEFFS, 16, maximum coefficients per frame; one ring slot size.
- DEPTH_FRAMES, 8, ring depth in frames; power of 2, at least 2.

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous reset, active-high
- mfcc_in  in  COEF_W  coefficient from accelerator
- mfcc_in_valid  in  1  coefficient strobe; no ready is returned
- num_mfcc_coeffs  in  8  coefficients per frame; sampled at frame start
- feat_out  out  COEF_W  coefficient to classifier
- feat_valid  out  1  feat_out valid
- feat_ready  in  1  classifier accepts
- feat_first  out  1  feat_out is coefficient 0 of its frame
- feat_last  out  1  feat_out is the final coefficient of its frame
- frames_avail  out  $clog2(DEPTH_FRAMES)+1  committed frames not yet fully read
- overflow  out  1  sticky; at least one frame dropped
- clear_ovf  in  1  clears overflow

Behaviour:
- Reset (clk edge with rst=1):
  - feat_valid=0, feat_first=0, feat_last=0, feat_out=0.
  - frames_avail=0, overflow=0.
  - Pointers cleared; both FSMs go to their idle state.
  - Reset mid-frame or mid-read discards all buffer contents.
- Effective frame length N: num_mfcc_coeffs clamped to the range 1..MAX_COEFFS (0 gives 1; values above MAX_COEFFS give MAX_COEFFS).
  - N is latched on the first coefficient of each frame.
  - N is stored per slot so the read side uses the length the frame was written with.
- Write FSM states: W_IDLE, W_FILL, W_DROP.
  - W_IDLE, mfcc_in_valid=1:
    - If frames_avail<DEPTH_FRAMES: write coefficient 0 into slot wr_ptr, then go to W_FILL; if N=1, commit immediately and stay in W_IDLE.
    - Else: set overflow and go to W_DROP.
  - W_FILL: each valid coefficient is written at index wcnt. On the coefficient at index N-1, commit (wr_ptr+1, frames_avail+1) and return to W_IDLE.
  - W_DROP: counts N coefficients and discards them, then returns to W_IDLE. No buffer write. frames_avail unchanged.
  - Gaps in mfcc_in_valid are allowed in every state; the counters simply hold.
- Read FSM states: R_IDLE, R_FETCH, R_STREAM.
  - R_IDLE: if frames_avail>0, go to R_FETCH and issue a synchronous RAM read at (rd_ptr, 0).
  - R_FETCH: the RAM data is registered into feat_out; feat_valid=1, feat_first=1; go to R_STREAM.
  - R_STREAM: feat_out, feat_first and feat_last hold stable while feat_valid=1 and feat_ready=0.
    - On handshake of a non-last coefficient: the next coefficient is presented the following cycle. Full throughput of 1 coefficient/cycle is required, using a prefetch/skid register.
    - On handshake with feat_last=1: release the slot (rd_ptr+1, frames_avail-1). Go to R_FETCH if further frames remain, else R_IDLE.
    - feat_valid deasserts for 1 cycle between frames (fetch bubble).
- Latency: commit at edge T gives feat_valid=1 at edge T+2 when the reader is idle.
- Simultaneous commit and release in the same cycle: frames_avail unchanged; both pointers advance.
- Full-check timing: the full check happens only at frame start. A release in the same cycle as coefficient 0 does not rescue that frame; it is dropped.
- Pointers wrap modulo DEPTH_FRAMES. frames_avail distinguishes full from empty.
- clear_ovf clears overflow. If a drop occurs in the same cycle, the set wins.
- Memory: DEPTH_FRAMES*MAX_COEFFS x COEF_W, one write port and one synchronous read port, addressed as {slot, index}.

Optional Feature:
- Macro: MFCC_DROP_CNT_EN.
- Defined:
  - Adds output drop_count, 16 bits.
  - Increments on every entry to W_DROP and saturates at 0xFFFF.
  - Reset to 0 by rst, and by clear_ovf in the same way as overflow.
- Undefined: the port and its counter are absent; the overflow flag alone reports drops.

Test Plan:
- Single frame, reader always ready: num_mfcc_coeffs=4, coefficients 0x11,0x22,0x33,0x44 on consecutive cycles -> feat_valid rises 2 cycles after 0x44. Output is 0x11 (first=1), 0x22, 0x33, 0x44 (last=1) on 4 consecutive cycles. frames_avail goes 1 then 0.
- Backpressure: same frame, feat_ready toggled 1,0,0,1,... -> no coefficient lost or duplicated; feat_out stable during stalls; exactly 4 handshakes.
- Overflow: DEPTH_FRAMES=8, feat_ready=0, 9 frames of 4 coefficients -> frames_avail=8, overflow=1, drop_count=1 (macro defined). Then feat_ready=1 replays frames 1-8 in order; frame 9 never appears.
- Length clamp and per-slot length: num_mfcc_coeffs=0, then 20, then 3 -> frames of 1, 16 and 3 coefficients; feat_last asserts on coefficients 1, 16 and 3 respectively.
- Simultaneous commit and release, with a ring of 2 frames held at frames_avail=2 -> frames_avail stays 2, and the pointer wraps correctly across 20 frames.
- Reset mid-frame: rst after coefficient 2 of 4 -> all outputs return to reset values. The next full frame is delivered intact, with first=1 on its coefficient 0.
